// File: rtl/phy_pkg.sv
// Shared definitions for the UPDI physical-level frame receiver.
// Frame layout: start bit, eight data bits LSB first, even parity, two stop bits.
package phy_pkg;

   localparam int FRAME_W = 12;
   localparam int START_B = 0;
   localparam int PAR_B   = 9;
   localparam int STOP0_B = 10;
   localparam int STOP1_B = 11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HUNT  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      CHECK = 3'd4,
      WRITE = 3'd5,
      DONE  = 3'd6
   } rx_state_t;

   // Even parity over data bits plus the parity bit itself.
   function automatic logic frame_parity_ok(input logic [FRAME_W-1:0] f);
      return ~(^f[PAR_B:START_B+1]);
   endfunction

   function automatic logic frame_stop_ok(input logic [FRAME_W-1:0] f);
      return f[STOP1_B] & f[STOP0_B];
   endfunction

endpackage

// File: rtl/phy_rx_sampler.sv
// RX line front end: 2-flop synchronizer, falling-edge detect and the
// bit-period counter that produces mid-bit sampling ticks.
module phy_rx_sampler #(
   parameter int OVS = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic prdata,
   input  logic load_half,
   input  logic load_full,
   output logic rxs,
   output logic fall,
   output logic tick
);

   localparam int CW = $clog2(OVS);

   logic sync0_r;
   logic sync1_r;
   logic prev_r;
   logic [CW-1:0] cnt_r;

   // Synchronizer chain plus one extra stage for edge detection; idles high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync0_r <= 1'b1;
         sync1_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync0_r <= prdata;
         sync1_r <= sync0_r;
         prev_r  <= sync1_r;
      end
   end

   // Down-counter: half-bit reload aligns to mid-start, full reload steps bit to bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (load_half) begin
         cnt_r <= CW'(OVS / 2 - 1);
      end else if (load_full) begin
         cnt_r <= CW'(OVS - 1);
      end else if (cnt_r != {CW{1'b0}}) begin
         cnt_r <= cnt_r - CW'(1);
      end
   end

   assign rxs  = sync1_r;
   assign fall = prev_r & ~sync1_r;
   assign tick = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/phy_frame_rx.sv
// UPDI frame receiver: recovers 12-bit frames from the RX line and writes
// each raw frame word into the frame SRAM, flagging parity/stop/break.
module phy_frame_rx
   import phy_pkg::*;
#(
   parameter int OVS    = 16,
   parameter int WORDS  = 128,
   parameter int ADDR_W = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ren,
   input  logic               prdata,
   output logic               csb0,
   output logic               web0,
   output logic [ADDR_W-1:0]  addr0,
   output logic [FRAME_W-1:0] o_data,
   output logic               rend,
   output logic               perr,
   output logic               ferr,
   output logic               brk,
   output logic               busy
);

   localparam logic [3:0] LAST_BIT = 4'(STOP1_B);

   rx_state_t state_r;
   rx_state_t state_n;

   logic rxs_s;
   logic fall_s;
   logic tick_s;
   logic load_half_s;
   logic load_full_s;
   logic shift_s;
   logic break_s;

   logic [FRAME_W-1:0] frame_r;
   logic [3:0]         bit_cnt_r;
   logic [ADDR_W-1:0]  addr_r;
   logic               csb0_r;
   logic               web0_r;
   logic [FRAME_W-1:0] o_data_r;
   logic               rend_r;
   logic               perr_r;
   logic               ferr_r;
   logic               brk_r;
   logic               busy_r;

   phy_rx_sampler #(.OVS(OVS)) u_sampler (
      .clk       (clk),
      .rst       (rst),
      .prdata    (prdata),
      .load_half (load_half_s),
      .load_full (load_full_s),
      .rxs       (rxs_s),
      .fall      (fall_s),
      .tick      (tick_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic and per-cycle datapath strobes.
   always_comb begin
      state_n     = state_r;
      load_half_s = 1'b0;
      load_full_s = 1'b0;
      shift_s     = 1'b0;
      break_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (!ren) state_n = HUNT;
            else      state_n = IDLE;
         end
         HUNT: begin
            if (ren) begin
               state_n = IDLE;
            end else if (fall_s) begin
               load_half_s = 1'b1;
               state_n     = START;
            end else begin
               state_n = HUNT;
            end
         end
         START: begin
            if (ren) begin
               state_n = IDLE;
            end else if (tick_s) begin
               if (rxs_s) begin
                  state_n = HUNT;
               end else begin
                  shift_s     = 1'b1;
                  load_full_s = 1'b1;
                  state_n     = DATA;
               end
            end else begin
               state_n = START;
            end
         end
         DATA: begin
            if (ren) begin
               state_n = IDLE;
            end else if (tick_s) begin
               shift_s = 1'b1;
               if (bit_cnt_r == LAST_BIT) begin
                  state_n = CHECK;
               end else begin
                  load_full_s = 1'b1;
                  state_n     = DATA;
               end
            end else begin
               state_n = DATA;
            end
         end
         CHECK: begin
            // An all-zero frame is a break; the edge detector keeps HUNT
            // quiet until the line has returned high.
            if (ren) begin
               state_n = IDLE;
            end else if (frame_r == {FRAME_W{1'b0}}) begin
               break_s = 1'b1;
               state_n = HUNT;
            end else begin
               state_n = WRITE;
            end
         end
         WRITE: begin
            if (ren)                                  state_n = IDLE;
            else if (addr_r == ADDR_W'(WORDS - 1))    state_n = DONE;
            else                                      state_n = HUNT;
         end
         DONE: begin
            if (ren) state_n = IDLE;
            else     state_n = DONE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Frame shift register (first line bit ends up in bit 0) and bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_r   <= {FRAME_W{1'b0}};
         bit_cnt_r <= 4'd0;
      end else if (shift_s) begin
         frame_r   <= {rxs_s, frame_r[FRAME_W-1:1]};
         bit_cnt_r <= (state_r == START) ? 4'd1 : bit_cnt_r + 4'd1;
      end
   end

   // Outputs are registered from the next state so strobes align with WRITE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_r   <= {ADDR_W{1'b0}};
         csb0_r   <= 1'b1;
         web0_r   <= 1'b1;
         o_data_r <= {FRAME_W{1'b0}};
         rend_r   <= 1'b0;
         perr_r   <= 1'b0;
         ferr_r   <= 1'b0;
         brk_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         if (state_n == IDLE) begin
            addr_r <= {ADDR_W{1'b0}};
         end else if (state_r == WRITE) begin
            addr_r <= (addr_r == ADDR_W'(WORDS - 1)) ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1);
         end
         csb0_r <= (state_n != WRITE);
         web0_r <= (state_n != WRITE);
         if (state_n == WRITE) begin
            o_data_r <= frame_r;
         end
         perr_r <= (state_n == WRITE) && !frame_parity_ok(frame_r);
         ferr_r <= (state_n == WRITE) && !frame_stop_ok(frame_r);
         brk_r  <= break_s;
         rend_r <= (state_n == DONE);
         busy_r <= (state_n != IDLE) && (state_n != DONE);
      end
   end

   assign csb0   = csb0_r;
   assign web0   = web0_r;
   assign addr0  = addr_r;
   assign o_data = o_data_r;
   assign rend   = rend_r;
   assign perr   = perr_r;
   assign ferr   = ferr_r;
   assign brk    = brk_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_phy_frame_rx.sv
// Directed bench for phy_frame_rx: a frame-level model predicts every memory
// write and break pulse; a per-cycle monitor checks the DUT against it.
module tb_phy_frame_rx;

   localparam int OVS    = 16;
   localparam int WORDS  = 128;
   localparam int ADDR_W = 7;

   logic clk;
   logic rst;
   logic ren;
   logic prdata;
   logic csb0;
   logic web0;
   logic [ADDR_W-1:0] addr0;
   logic [11:0] o_data;
   logic rend;
   logic perr;
   logic ferr;
   logic brk;
   logic busy;

   phy_frame_rx #(.OVS(OVS), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .ren    (ren),
      .prdata (prdata),
      .csb0   (csb0),
      .web0   (web0),
      .addr0  (addr0),
      .o_data (o_data),
      .rend   (rend),
      .perr   (perr),
      .ferr   (ferr),
      .brk    (brk),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [11:0]       data;
      logic              perr;
      logic              ferr;
   } wr_t;

   wr_t exp_q[$];
   int  brk_exp    = 0;
   int  model_cnt  = 0;
   int  vectors    = 0;
   int  miscompares = 0;

   function automatic logic [11:0] make_frame(input logic [7:0] d, input logic par_bad,
                                              input logic stop_bad);
      logic par;
      par = (^d) ^ par_bad;
      return {(stop_bad ? 2'b01 : 2'b11), par, d, 1'b0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Frame-level model: what a finished frame must cause in the current session.
   task automatic model_frame(input logic [11:0] w);
      wr_t e;
      if (model_cnt < WORDS) begin
         if (w == 12'h000) begin
            brk_exp++;
         end else begin
            e.addr = ADDR_W'(model_cnt);
            e.data = w;
            e.perr = ^w[9:1];
            e.ferr = ~(w[11] & w[10]);
            exp_q.push_back(e);
            model_cnt++;
         end
      end
   endtask

   task automatic set_ren(input logic v);
      ren = v;
      if (v) model_cnt = 0;
   endtask

   // One clock cycle; outputs are compared at the falling edge.
   task automatic step();
      wr_t e;
      @(negedge clk);
      if (rst) begin
         if (!csb0) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: addr=%0d data=%h expected no write", addr0, o_data);
            end else begin
               e = exp_q.pop_front();
               check("write", {12'h0, web0, addr0, o_data, perr, ferr},
                     {12'h0, 1'b0, e.addr, e.data, e.perr, e.ferr});
            end
         end else if (perr || ferr || !web0) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_strobe: perr=%b ferr=%b web0=%b expected 0 0 1", perr, ferr, web0);
         end
         if (brk) begin
            if (brk_exp == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_brk: brk=1 expected 0");
            end else begin
               check("brk_pulse", 32'(brk), 32'd1);
               brk_exp--;
            end
         end
      end
   endtask

   task automatic send_bit(input logic b);
      prdata = b;
      repeat (OVS) step();
   endtask

   task automatic send_frame(input logic [11:0] w);
      logic [11:0] v;
      v = w;
      model_frame(w);
      for (int i = 0; i < 12; i++) send_bit(v[i]);
      prdata = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 64; i++) begin
         if (exp_q.size() == 0 && brk_exp == 0) break;
         step();
      end
      check(name, 32'(exp_q.size() + brk_exp), 32'd0);
      exp_q.delete();
      brk_exp = 0;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {19'h0, csb0, web0, addr0, o_data, rend, perr, ferr, brk, busy},
            {19'h0, 1'b1, 1'b1, 7'd0, 12'h000, 5'b00000});
   endtask

   initial begin
      logic [11:0] w;
      rst    = 1'b0;
      ren    = 1'b1;
      prdata = 1'b1;
      #12;
      check_reset_outputs("reset_values");
      rst = 1'b1;
      repeat (3) step();
      check("idle_busy", 32'(busy), 32'd0);

      // Model pins against hand-computed words.
      check("pin_frame_a5", 32'(make_frame(8'hA5, 1'b0, 1'b0)), 32'h0000_0D4A);
      check("pin_frame_c02", 32'(make_frame(8'h01, 1'b1, 1'b0)), 32'h0000_0C02);

      // Clean frame 0xA5.
      set_ren(1'b0);
      repeat (2) step();
      check("hunt_busy", 32'(busy), 32'd1);
      send_frame(12'hD4A);
      drain("frame_a5_done");
      check("addr_after_a5", 32'(addr0), 32'd1);
      check("odata_a5", 32'(o_data), 32'h0000_0D4A);

      // New session: parity error frame lands at address 0.
      set_ren(1'b1);
      repeat (2) step();
      check("idle_addr_zero", 32'(addr0), 32'd0);
      set_ren(1'b0);
      repeat (4) step();
      send_frame(12'hC02);
      drain("parity_frame_done");

      // Stop-bit error frame.
      send_frame(make_frame(8'h3C, 1'b0, 1'b1));
      repeat (8) step();
      drain("stop_frame_done");

      // Short glitch: false start, no write, address kept.
      prdata = 1'b0;
      repeat (2) step();
      prdata = 1'b1;
      repeat (40) step();
      check("glitch_addr", 32'(addr0), 32'd2);
      check("glitch_busy", 32'(busy), 32'd1);

      // Break: 13 bit-times low, then a valid frame at the same address.
      send_frame(12'h000);
      send_bit(1'b0);
      prdata = 1'b1;
      repeat (20) step();
      drain("break_done");
      check("break_addr", 32'(addr0), 32'd2);
      send_frame(make_frame(8'h5A, 1'b0, 1'b0));
      drain("post_break_done");

      // Full session of back-to-back frames.
      set_ren(1'b1);
      repeat (2) step();
      set_ren(1'b0);
      repeat (4) step();
      for (int i = 0; i < WORDS; i++) begin
         w = make_frame(8'(i * 37 + 5), 1'b0, 1'b0);
         send_frame(w);
      end
      repeat (4) step();
      drain("session_done");
      check("done_rend", 32'(rend), 32'd1);
      check("done_addr", 32'(addr0), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      send_frame(make_frame(8'h77, 1'b0, 1'b0));
      repeat (4) step();
      check("done_ignores_line", 32'(rend), 32'd1);
      set_ren(1'b1);
      step();
      check("rend_cleared", 32'(rend), 32'd0);

      // Abort in the middle of data bit 4.
      repeat (3) step();
      set_ren(1'b0);
      repeat (4) step();
      w = make_frame(8'hE1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(w[i]);
      prdata = w[4];
      repeat (OVS / 2) step();
      set_ren(1'b1);
      step();
      check("abort_busy_rend", {30'h0, busy, rend}, 32'd0);
      prdata = 1'b1;
      repeat (20 * OVS) step();
      check("abort_no_write", 32'(addr0), 32'd0);

      // Asynchronous reset in the middle of DATA.
      set_ren(1'b0);
      repeat (4) step();
      send_frame(make_frame(8'h99, 1'b0, 1'b0));
      drain("pre_reset_frame");
      w = make_frame(8'h42, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(w[i]);
      check("mid_data_busy", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1 check_reset_outputs("async_reset_mid_data");
      prdata = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      repeat (3) step();
      rst = 1'b1;
      repeat (3) step();
      check("after_reset_addr", 32'(addr0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
